logic_capture_mem_arb: RTL

- Arbitrates two simple memory-request masters onto the single request port of the capture AXI bridge.
  - Port 0: capture write stream, burst-capable writes.
  - Port 1: host readback of the capture buffer, reads.
- Tracks outstanding transactions in order, so each ack, error and read-data beat is routed back to the requester that issued it.
- Sits between the capture write path / readback engine and the AXI memory bridge.

---
 rtl/logic_capture_mem_arb_if.sv | 63 ++++++
 rtl/logic_capture_mem_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/logic_capture_mem_arb_if.sv
// Request/response bundle between the two capture masters, the arbiter
// and the downstream AXI memory bridge.
interface logic_capture_mem_arb_if;
  logic [3:0]  inport0_wr_i;
  logic        inport0_rd_i;
  logic [7:0]  inport0_len_i;
  logic [31:0] inport0_addr_i;
  logic [31:0] inport0_write_data_i;
  logic        inport0_accept_o;
  logic        inport0_ack_o;
  logic        inport0_error_o;
  logic [31:0] inport0_read_data_o;

  logic [3:0]  inport1_wr_i;
  logic        inport1_rd_i;
  logic [7:0]  inport1_len_i;
  logic [31:0] inport1_addr_i;
  logic [31:0] inport1_write_data_i;
  logic        inport1_accept_o;
  logic        inport1_ack_o;
  logic        inport1_error_o;
  logic [31:0] inport1_read_data_o;

  logic [3:0]  outport_wr_o;
  logic        outport_rd_o;
  logic [7:0]  outport_len_o;
  logic [31:0] outport_addr_o;
  logic [31:0] outport_write_data_o;
  logic        outport_accept_i;
  logic        outport_ack_i;
  logic        outport_error_i;
  logic [31:0] outport_read_data_i;

  modport slave (
    input  inport0_wr_i, inport0_rd_i, inport0_len_i,
    input  inport0_addr_i, inport0_write_data_i,
    output inport0_accept_o, inport0_ack_o,
    output inport0_error_o, inport0_read_data_o,
    input  inport1_wr_i, inport1_rd_i, inport1_len_i,
    input  inport1_addr_i, inport1_write_data_i,
    output inport1_accept_o, inport1_ack_o,
    output inport1_error_o, inport1_read_data_o,
    output outport_wr_o, outport_rd_o, outport_len_o,
    output outport_addr_o, outport_write_data_o,
    input  outport_accept_i, outport_ack_i,
    input  outport_error_i, outport_read_data_i
  );

  modport master (
    output inport0_wr_i, inport0_rd_i, inport0_len_i,
    output inport0_addr_i, inport0_write_data_i,
    input  inport0_accept_o, inport0_ack_o,
    input  inport0_error_o, inport0_read_data_o,
    output inport1_wr_i, inport1_rd_i, inport1_len_i,
    output inport1_addr_i, inport1_write_data_i,
    input  inport1_accept_o, inport1_ack_o,
    input  inport1_error_o, inport1_read_data_o,
    input  outport_wr_o, outport_rd_o, outport_len_o,
    input  outport_addr_o, outport_write_data_o,
    output outport_accept_i, outport_ack_i,
    output outport_error_i, outport_read_data_i
  );
endinterface

// File: rtl/logic_capture_mem_arb.sv
// Two-master arbiter with in-order response tracking for the capture bridge.
// LOGIC_CAPTURE_MEM_ARB_RR_EN selects round-robin instead of hog-guarded priority.
module logic_capture_mem_arb #(
  parameter int MAX_HOG      = 4,
  parameter int TRACK_DEPTH  = 16,
  parameter int TRACK_ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  logic_capture_mem_arb_if.slave bus,
  output logic                  err_unexpected_ack_o
);
  localparam int CNT_W = TRACK_ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BURST} state_t;

  state_t                  r_state;
  logic                    r_grant;
  logic [7:0]              r_remain;
  logic [TRACK_ADDR_W-1:0] r_wptr;
  logic [TRACK_ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic [7:0]              r_ack_cnt;
  logic                    r_err;
  logic                    r_trk_port [TRACK_DEPTH];
  logic                    r_trk_rd   [TRACK_DEPTH];
  logic [7:0]              r_trk_len  [TRACK_DEPTH];

  logic        w_req0, w_req1, w_winner, w_grant, w_req_g;
  logic [3:0]  w_wr_g;
  logic        w_rd_g;
  logic [7:0]  w_len_g;
  logic [31:0] w_addr_g, w_data_g;
  logic        w_head, w_empty, w_full, w_ack, w_pop;
  logic        w_gate, w_acc, w_fire, w_push, w_ack0, w_ack1;

  assign w_req0 = (|bus.inport0_wr_i) | bus.inport0_rd_i;
  assign w_req1 = (|bus.inport1_wr_i) | bus.inport1_rd_i;

`ifdef LOGIC_CAPTURE_MEM_ARB_RR_EN
  assign w_winner = (w_req0 && w_req1) ? !r_grant : (!w_req0 && w_req1);
`else
  localparam int HOG_W = $clog2(MAX_HOG + 1);
  logic [HOG_W-1:0] r_hog;
  assign w_winner = w_req1 && !(w_req0 && (r_hog < HOG_W'(MAX_HOG)));
`endif

  // IDLE drives the fresh winner; HOLD/BURST keep the grant frozen
  assign w_grant  = (r_state == S_IDLE) ? w_winner : r_grant;
  assign w_req_g  = w_grant ? w_req1 : w_req0;
  assign w_wr_g   = w_grant ? bus.inport1_wr_i : bus.inport0_wr_i;
  assign w_rd_g   = w_grant ? bus.inport1_rd_i : bus.inport0_rd_i;
  assign w_len_g  = w_grant ? bus.inport1_len_i : bus.inport0_len_i;
  assign w_addr_g = w_grant ? bus.inport1_addr_i : bus.inport0_addr_i;
  assign w_data_g = w_grant ? bus.inport1_write_data_i
                            : bus.inport0_write_data_i;

  assign w_head  = (r_state != S_BURST);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(TRACK_DEPTH));
  assign w_ack   = bus.outport_ack_i && !w_empty;
  assign w_pop   = w_ack && (!r_trk_rd[r_rptr] ||
                   (r_ack_cnt == r_trk_len[r_rptr]));
  assign w_gate  = !w_head || !w_full || w_pop;
  assign w_acc   = bus.outport_accept_i && w_gate && !rst_i;
  assign w_fire  = w_acc && w_req_g;
  assign w_push  = w_fire && w_head;

  assign bus.outport_wr_o         = rst_i ? 4'd0  : w_wr_g;
  assign bus.outport_rd_o         = rst_i ? 1'b0  : w_rd_g;
  assign bus.outport_len_o        = rst_i ? 8'd0  : w_len_g;
  assign bus.outport_addr_o       = rst_i ? 32'd0 : w_addr_g;
  assign bus.outport_write_data_o = rst_i ? 32'd0 : w_data_g;
  assign bus.inport0_accept_o     = w_acc && !w_grant;
  assign bus.inport1_accept_o     = w_acc && w_grant;

  assign w_ack0 = w_ack && !r_trk_port[r_rptr];
  assign w_ack1 = w_ack && r_trk_port[r_rptr];
  assign bus.inport0_ack_o       = w_ack0;
  assign bus.inport1_ack_o       = w_ack1;
  assign bus.inport0_error_o     = w_ack0 && bus.outport_error_i;
  assign bus.inport1_error_o     = w_ack1 && bus.outport_error_i;
  assign bus.inport0_read_data_o = w_ack0 ? bus.outport_read_data_i : 32'd0;
  assign bus.inport1_read_data_o = w_ack1 ? bus.outport_read_data_i : 32'd0;
  assign err_unexpected_ack_o    = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_remain <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (r_state == S_IDLE && w_req_g) r_grant <= w_winner;
          if (w_fire) begin
            if ((|w_wr_g) && w_len_g != 8'd0) begin
              r_state  <= S_BURST;
              r_remain <= w_len_g - 8'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_req_g) begin
            r_state <= S_HOLD;
          end
        end
        S_BURST: begin
          if (w_fire) begin
            if (r_remain == 8'd0) r_state <= S_IDLE;
            else r_remain <= r_remain - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ack_cnt <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_pop) r_ack_cnt <= 8'd0;
      else if (w_ack) r_ack_cnt <= r_ack_cnt + 8'd1;
      if (bus.outport_ack_i && w_empty) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_trk_port[r_wptr] <= w_grant;
      r_trk_rd[r_wptr]   <= w_rd_g;
      r_trk_len[r_wptr]  <= w_len_g;
    end
  end

`ifndef LOGIC_CAPTURE_MEM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hog <= '0;
    end else if (!w_req1 || (w_push && w_grant)) begin
      r_hog <= '0;
    end else if (w_push && r_hog != HOG_W'(MAX_HOG)) begin
      r_hog <= r_hog + 1'b1;
    end
  end
`endif
endmodule
